uart_rx_deser: RTL and testbench

- Oversampling UART receive deserializer.
- Sits directly upstream of the UART RX command interpreter and feeds it the received byte plus a one-cycle "byte complete" strobe.
- Samples the asynchronous serial line on baud-generator ticks (OVERSAMPLE per bit), checks start and stop bits, and assembles LSB-first data into a byte.
- Frame errors are reported separately; a bad frame never produces a byte strobe.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_rx_deser_if.sv | 26 ++
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx_deser.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   - 4-bit state encodings. The command interpreter uses the same encoding style.
//   - Default OVERSAMPLE / DATA_BITS values.
//   - ASCII constants used by the downstream command interpreter.
//   - A parity helper function.
// The PARITY encoding is always defined. Only builds with UART_RX_PARITY_EN
// defined ever reach that state.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    localparam logic [3:0] ST_IDLE_C      = 4'd0;
    localparam logic [3:0] ST_START_C     = 4'd1;
    localparam logic [3:0] ST_DATA_C      = 4'd2;
    localparam logic [3:0] ST_PARITY_C    = 4'd3;
    localparam logic [3:0] ST_STOP_C      = 4'd4;
    localparam logic [3:0] ST_WAIT_HIGH_C = 4'd5;

    typedef enum logic [3:0] {
        RX_IDLE      = ST_IDLE_C,
        RX_START     = ST_START_C,
        RX_DATA      = ST_DATA_C,
        RX_PARITY    = ST_PARITY_C,
        RX_STOP      = ST_STOP_C,
        RX_WAIT_HIGH = ST_WAIT_HIGH_C
    } rx_state_e;

    localparam logic [7:0] ASCII_W     = 8'h77;
    localparam logic [7:0] ASCII_R     = 8'h72;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    // Returns 1 when the vector holds an odd number of ones.
    // Callers zero-extend narrower vectors.
    function automatic logic parity_odd(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if: groups the serial-side inputs and byte-side outputs of
// uart_rx_deser.
//   master: the environment. It drives the line, the tick and the enable,
//           and receives the byte, strobe, frame error and busy flag.
//   slave : the deserializer itself.
interface uart_rx_deser_if import uart_pkg::*; #(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 iUART_RX;
    logic                 iUART_RX_TICK;
    logic                 iUART_RX_EN;
    logic [DATA_BITS-1:0] oSER2PAR;
    logic                 oUART_RX_STOP;
    logic                 oFRAME_ERR;
    logic                 oRX_BUSY;

    modport master (
        output iUART_RX, iUART_RX_TICK, iUART_RX_EN,
        input  oSER2PAR, oUART_RX_STOP, oFRAME_ERR, oRX_BUSY
    );

    modport slave (
        input  iUART_RX, iUART_RX_TICK, iUART_RX_EN,
        output oSER2PAR, oUART_RX_STOP, oFRAME_ERR, oRX_BUSY
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for one asynchronous input.
// Both flops reset to 1, so an idle-high line never shows a false low edge
// when reset is released.
// Ports:
//   iCLK    destination clock
//   iRESET  asynchronous, active-high reset
//   async_i asynchronous input
//   sync_o  synchronized output, two iCLK cycles of latency
module uart_rx_sync (
    input  logic iCLK,
    input  logic iRESET,
    input  logic async_i,
    output logic sync_o
);
    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next-state values for the two synchronizer stages.
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    // Synchronizer stages. Both reset to the idle-high level.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;
endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling UART receive deserializer.
// The serial line is sampled on baud ticks (OVERSAMPLE ticks per bit). The
// block checks the start and stop bits and assembles LSB-first data.
//   - A good frame: the byte goes to oSER2PAR with a one-cycle oUART_RX_STOP.
//   - A bad frame:  a one-cycle oFRAME_ERR pulse, and oSER2PAR is left as is.
// Optional macro UART_RX_PARITY_EN: adds an even-parity bit between the data
// and the stop bit.
// Ports:
//   iCLK, iRESET     system clock and asynchronous active-high reset
//   rx_if (slave):
//     iUART_RX       serial line
//     iUART_RX_TICK  oversample tick
//     iUART_RX_EN    receiver enable
//     oSER2PAR       last good byte
//     oUART_RX_STOP  byte strobe
//     oFRAME_ERR     frame error pulse
//     oRX_BUSY       high whenever the receiver is not idle
module uart_rx_deser import uart_pkg::*; #(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic            iCLK,
    input  logic            iRESET,
    uart_rx_deser_if.slave  rx_if
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e            state_d, state_q;
    logic [TICK_W-1:0]    tick_cnt_d, tick_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_d, bit_cnt_q;
    logic [DATA_BITS-1:0] shift_d, shift_q;
    logic [DATA_BITS-1:0] data_d, data_q;
    logic                 strobe_d, strobe_q;
    logic                 ferr_d, ferr_q;
    logic                 busy_d, busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_d, par_err_q;
`endif

    uart_rx_sync u_sync (
        .iCLK    (iCLK),
        .iRESET  (iRESET),
        .async_i (rx_if.iUART_RX),
        .sync_o  (rx_s)
    );

    // Next-state logic: framing FSM, counters, shift register and output pulses.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        strobe_d   = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d  = par_err_q;
`endif
        if (!rx_if.iUART_RX_EN) begin
            // Disabling the receiver abandons any frame in progress.
            // The last good byte on oSER2PAR is kept.
            state_d    = RX_IDLE;
            tick_cnt_d = TICK_ZERO;
            bit_cnt_d  = BIT_ZERO;
            shift_d    = '0;
`ifdef UART_RX_PARITY_EN
            par_err_d  = 1'b0;
`endif
        end else if (rx_if.iUART_RX_TICK) begin
            case (state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_d    = RX_START;
                        tick_cnt_d = TICK_ZERO;
`ifdef UART_RX_PARITY_EN
                        par_err_d  = 1'b0;
`endif
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
                RX_START: begin
                    // Check again at mid start bit. A line that has gone back
                    // high by then was only a glitch.
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = TICK_ZERO;
                        bit_cnt_d  = BIT_ZERO;
                        if (!rx_s) begin
                            state_d = RX_DATA;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
                RX_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // LSB first: each new bit enters at the MSB, and
                        // earlier bits move down toward bit 0.
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = TICK_ZERO;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
                            state_d   = RX_PARITY;
`else
                            state_d   = RX_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // Even parity: the data bits plus the parity bit must
                        // contain an even number of ones.
                        par_err_d  = parity_odd(32'(shift_q)) ^ rx_s;
                        tick_cnt_d = TICK_ZERO;
                        state_d    = RX_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
`endif
                RX_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = TICK_ZERO;
                        if (rx_s) begin
                            state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_err_q) begin
                                ferr_d = 1'b1;
                            end else begin
                                data_d   = shift_q;
                                strobe_d = 1'b1;
                            end
`else
                            data_d   = shift_q;
                            strobe_d = 1'b1;
`endif
                        end else begin
                            // A low stop bit may be the start of a break.
                            // Wait for the line to go high before accepting
                            // another start bit.
                            ferr_d  = 1'b1;
                            state_d = RX_WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_WAIT_HIGH;
                    end
                end
                default: begin
                    state_d    = RX_IDLE;
                    tick_cnt_d = TICK_ZERO;
                    bit_cnt_d  = BIT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // Registered here so that oRX_BUSY tracks the state register exactly.
        busy_d = (state_d != RX_IDLE);
    end

    // State and output registers.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q    <= RX_IDLE;
            tick_cnt_q <= TICK_ZERO;
            bit_cnt_q  <= BIT_ZERO;
            shift_q    <= '0;
            data_q     <= '0;
            strobe_q   <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign rx_if.oSER2PAR      = data_q;
    assign rx_if.oUART_RX_STOP = strobe_q;
    assign rx_if.oFRAME_ERR    = ferr_q;
    assign rx_if.oRX_BUSY      = busy_q;
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: directed testbench for uart_rx_deser.
// Each frame the bench sends adds one expected event to a queue: a byte, or
// a frame error. The event carries the cycle window in which it must appear.
// The window is derived from the frame's line timing.
// A single compare process checks the DUT outputs on every negedge:
//   - any pulse against the head of the queue;
//   - oSER2PAR against the last good byte;
//   - the outputs against their reset values whenever reset is high.
// Compile with +define+UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_deser;
    import uart_pkg::*;

    localparam int BIT_CLK = 64;                 // 16 ticks x 4 clocks
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Offset from the line falling edge to the cycle the pulse is visible:
    // 2 synchronizer clocks + first tick, then mid start bit, then whole bits
    // up to the middle of the stop bit.
    localparam int STOP_OFF = (FRAME_BITS - 1) * BIT_CLK + BIT_CLK / 2 + 3;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         lo;
        int         hi;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_assert;
    int   n_fail;
    int   n_strobe;
    int   n_ferr;
    logic [7:0] model_last;
    exp_t exp_q[$];

    uart_rx_deser_if rx_if ();

    uart_rx_deser dut (
        .iCLK   (clk),
        .iRESET (rst),
        .rx_if  (rx_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Baud tick: one clock in every four.
    initial begin
        int tcnt;
        tcnt = 0;
        rx_if.iUART_RX_TICK = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            rx_if.iUART_RX_TICK = (tcnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert = n_assert + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        exp_t e;
        e.err  = !stop_bit || par_flip;
        e.data = d;
        e.lo   = cyc + STOP_OFF;
        e.hi   = cyc + STOP_OFF + 3;
        exp_q.push_back(e);
        rx_if.iUART_RX = 1'b0;
        step(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx_if.iUART_RX = d[i];
            step(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx_if.iUART_RX = (^d) ^ par_flip;
        step(BIT_CLK);
`endif
        rx_if.iUART_RX = stop_bit;
        step(BIT_CLK);
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        rx_if.iUART_RX = 1'b0;
        step(BIT_CLK);
        for (int i = 0; i < nbits; i++) begin
            rx_if.iUART_RX = d[i];
            step(BIT_CLK);
        end
    endtask

    // Compare process: checks the outputs against the model on every negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_last = 8'h00;
                check("reset_outputs",
                      {20'h0, rx_if.oSER2PAR, rx_if.oUART_RX_STOP, rx_if.oFRAME_ERR, rx_if.oRX_BUSY},
                      32'h0);
            end else begin
                if (rx_if.oUART_RX_STOP && rx_if.oFRAME_ERR)
                    check("strobe_and_ferr_together", 32'd1, 32'd0);
                if (rx_if.oUART_RX_STOP) begin
                    n_strobe = n_strobe + 1;
                    if (exp_q.size() == 0 || exp_q[0].err) begin
                        check("unexpected_strobe", {24'h0, rx_if.oSER2PAR}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_byte", {24'h0, rx_if.oSER2PAR}, {24'h0, e.data});
                        check("strobe_in_window", (cyc >= e.lo && cyc <= e.hi) ? 32'd1 : 32'd0, 32'd1);
                        model_last = e.data;
                    end
                end
                if (rx_if.oFRAME_ERR) begin
                    n_ferr = n_ferr + 1;
                    if (exp_q.size() == 0 || !exp_q[0].err) begin
                        check("unexpected_frame_err", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ferr_in_window", (cyc >= e.lo && cyc <= e.hi) ? 32'd1 : 32'd0, 32'd1);
                    end
                end
                check("ser2par_hold", {24'h0, rx_if.oSER2PAR}, {24'h0, model_last});
            end
        end
    end

    initial begin
        int s0;
        int f0;
        n_assert = 0;
        n_fail   = 0;
        n_strobe = 0;
        n_ferr   = 0;
        model_last = 8'h00;
        rx_if.iUART_RX    = 1'b1;
        rx_if.iUART_RX_EN = 1'b1;
        rst = 1'b1;
        step(6);
        check("reset_ser2par", {24'h0, rx_if.oSER2PAR}, 32'h00);
        check("reset_busy", {31'h0, rx_if.oRX_BUSY}, 32'd0);
        rst = 1'b0;
        step(20);

        // Single frame 0x77
        s0 = n_strobe; f0 = n_ferr;
        send_frame(ASCII_W, 1'b1, 1'b0);
        step(40);
        check("w_one_strobe", n_strobe - s0, 32'd1);
        check("w_no_ferr", n_ferr - f0, 32'd0);
        check("w_byte", {24'h0, rx_if.oSER2PAR}, 32'h77);
        check("w_busy_low", {31'h0, rx_if.oRX_BUSY}, 32'd0);
        check("w_queue_empty", exp_q.size(), 32'd0);

        // Glitch: line low for 5 ticks
        s0 = n_strobe; f0 = n_ferr;
        rx_if.iUART_RX = 1'b0;
        step(20);
        check("glitch_busy_mid", {31'h0, rx_if.oRX_BUSY}, 32'd1);
        rx_if.iUART_RX = 1'b1;
        step(100);
        check("glitch_no_pulses", (n_strobe - s0) + (n_ferr - f0), 32'd0);
        check("glitch_idle", {31'h0, rx_if.oRX_BUSY}, 32'd0);

        // Back-to-back frames 0x72 then 0x20
        s0 = n_strobe;
        send_frame(ASCII_R, 1'b1, 1'b0);
        send_frame(ASCII_SPACE, 1'b1, 1'b0);
        step(40);
        check("b2b_two_strobes", n_strobe - s0, 32'd2);
        check("b2b_last_byte", {24'h0, rx_if.oSER2PAR}, 32'h20);
        check("b2b_queue_empty", exp_q.size(), 32'd0);

        // Break: 0x55 with low stop bit, line low for 30 ticks from stop bit
        s0 = n_strobe; f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0);
        step(120 - BIT_CLK);
        check("break_one_ferr", n_ferr - f0, 32'd1);
        check("break_no_strobe", n_strobe - s0, 32'd0);
        check("break_hold_byte", {24'h0, rx_if.oSER2PAR}, 32'h20);
        check("break_busy_waiting", {31'h0, rx_if.oRX_BUSY}, 32'd1);
        rx_if.iUART_RX = 1'b1;
        step(12);
        check("break_released_idle", {31'h0, rx_if.oRX_BUSY}, 32'd0);
        step(100);
        check("break_no_extra_frames", (n_strobe - s0) + (n_ferr - f0), 32'd1);

        // Enable dropped in bit 4 of 0xA5, then clean 0x0D
        s0 = n_strobe; f0 = n_ferr;
        send_partial(8'hA5, 4);
        rx_if.iUART_RX = 1'b0;
        step(BIT_CLK / 2);
        rx_if.iUART_RX_EN = 1'b0;
        step(4);
        check("en_low_idle", {31'h0, rx_if.oRX_BUSY}, 32'd0);
        rx_if.iUART_RX = 1'b1;
        step(BIT_CLK);
        check("en_low_hold_byte", {24'h0, rx_if.oSER2PAR}, 32'h20);
        rx_if.iUART_RX_EN = 1'b1;
        step(BIT_CLK);
        send_frame(ASCII_CR, 1'b1, 1'b0);
        step(40);
        check("en_only_cr", n_strobe - s0, 32'd1);
        check("en_no_ferr", n_ferr - f0, 32'd0);
        check("en_cr_byte", {24'h0, rx_if.oSER2PAR}, 32'h0D);

        // Reset asserted in bit 4 of 0xA5, then clean 0x0D
        s0 = n_strobe; f0 = n_ferr;
        send_partial(8'hA5, 4);
        rx_if.iUART_RX = 1'b0;
        step(BIT_CLK / 2);
        rst = 1'b1;
        step(1);
        check("rst_mid_ser2par", {24'h0, rx_if.oSER2PAR}, 32'h00);
        check("rst_mid_busy", {31'h0, rx_if.oRX_BUSY}, 32'd0);
        rx_if.iUART_RX = 1'b1;
        step(10);
        rst = 1'b0;
        step(BIT_CLK);
        send_frame(ASCII_CR, 1'b1, 1'b0);
        step(40);
        check("rst_only_cr", n_strobe - s0, 32'd1);
        check("rst_no_ferr", n_ferr - f0, 32'd0);
        check("rst_cr_byte", {24'h0, rx_if.oSER2PAR}, 32'h0D);

`ifdef UART_RX_PARITY_EN
        // Parity: good parity, then a flipped parity bit
        s0 = n_strobe; f0 = n_ferr;
        send_frame(ASCII_W, 1'b1, 1'b0);
        step(40);
        check("par_good_strobe", n_strobe - s0, 32'd1);
        check("par_good_byte", {24'h0, rx_if.oSER2PAR}, 32'h77);
        s0 = n_strobe;
        send_frame(ASCII_CR, 1'b1, 1'b1);
        step(40);
        check("par_bad_ferr", n_ferr - f0, 32'd1);
        check("par_bad_no_strobe", n_strobe - s0, 32'd0);
        check("par_bad_hold_byte", {24'h0, rx_if.oSER2PAR}, 32'h77);
        check("par_idle_after", {31'h0, rx_if.oRX_BUSY}, 32'd0);
`endif

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
